// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase/fault types and lamp patterns for the lamp-bus monitor
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_GREEN,
        PH_YELLOW,
        PH_ALL_RED,
        PH_WALK,
        PH_DARK,
        PH_RED_YELLOW,
        PH_ILLEGAL,
        PH_UNKNOWN
    } phase_t;

    typedef enum logic [2:0] {
        FLT_NONE        = 3'd0,
        FLT_CONFLICT    = 3'd1,
        FLT_BAD_TRANS   = 3'd2,
        FLT_SHORT_DWELL = 3'd3,
        FLT_BAD_LEN     = 3'd4,
        FLT_STUCK       = 3'd5
    } fault_t;

    // Lamp vector order: {road_red, road_yellow, road_green, ped_red, ped_green}
    localparam logic [4:0] LAMP_GREEN      = 5'b00110;
    localparam logic [4:0] LAMP_YELLOW     = 5'b01010;
    localparam logic [4:0] LAMP_ALL_RED    = 5'b10010;
    localparam logic [4:0] LAMP_WALK       = 5'b10001;
    localparam logic [4:0] LAMP_DARK       = 5'b10000;
    localparam logic [4:0] LAMP_RED_YELLOW = 5'b11010;

    // WALK and DARK together form the pedestrian region
    function automatic logic is_ped(input phase_t p);
        return (p == PH_WALK) || (p == PH_DARK);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lamp bus plus monitor status signals
interface traffic_light_monitor_if;
    logic       road_red;
    logic       road_yellow;
    logic       road_green;
    logic       ped_red;
    logic       ped_green;
    logic       clr;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic       fs_active;
    logic       fs_road_yellow;

    modport master (
        output road_red, road_yellow, road_green, ped_red, ped_green, clr,
        input  fault, fault_code, fault_count, fs_active, fs_road_yellow
    );

    modport slave (
        input  road_red, road_yellow, road_green, ped_red, ped_green, clr,
        output fault, fault_code, fault_count, fs_active, fs_road_yellow
    );
endinterface

// File: rtl/lamp_phase_decoder.sv
// rtl/lamp_phase_decoder.sv - combinational lamp vector to phase decode
module lamp_phase_decoder
    import traffic_pkg::*;
(
    input  logic [4:0] lamp_i,
    output phase_t     phase_o
);

    // Any pattern outside the six legal ones is a lamp conflict
    always_comb begin
        phase_o = PH_ILLEGAL;
        case (lamp_i)
            LAMP_GREEN:      phase_o = PH_GREEN;
            LAMP_YELLOW:     phase_o = PH_YELLOW;
            LAMP_ALL_RED:    phase_o = PH_ALL_RED;
            LAMP_WALK:       phase_o = PH_WALK;
            LAMP_DARK:       phase_o = PH_DARK;
            LAMP_RED_YELLOW: phase_o = PH_RED_YELLOW;
            default:         phase_o = PH_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lamp sequence/dwell safety monitor; MON_FAILSAFE_EN builds the yellow flash failsafe
module traffic_light_monitor
    import traffic_pkg::*;
#(
`ifdef MON_FAILSAFE_EN
    parameter int unsigned FLASH_HALF  = 4,
`endif
    parameter int unsigned MIN_GREEN   = 6,
    parameter int unsigned YELLOW_CYC  = 2,
    parameter int unsigned ALL_RED_MIN = 3,
    parameter int unsigned RY_CYC      = 2,
    parameter int unsigned MAX_DWELL   = 16
) (
    input logic              clk,
    input logic              rst,
    traffic_light_monitor_if.slave bus
);

    localparam logic [7:0] MIN_GREEN_C   = 8'(MIN_GREEN);
    localparam logic [7:0] YELLOW_CYC_C  = 8'(YELLOW_CYC);
    localparam logic [7:0] ALL_RED_MIN_C = 8'(ALL_RED_MIN);
    localparam logic [7:0] RY_CYC_C      = 8'(RY_CYC);
    localparam logic [7:0] STUCK_AT_C    = 8'(MAX_DWELL - 1);

    logic [4:0] lamp_q;
    phase_t     lamp_phase;
    phase_t     cur_phase_q, cur_phase_d;
    phase_t     ped_origin_q, ped_origin_d;
    logic [7:0] dwell_q, dwell_d;
    logic       fault_q, fault_d;
    fault_t     code_q, code_d;
    logic [7:0] count_q, count_d;
    fault_t     event_code;
    logic       same_region;
    logic       legal_trans;
    logic       short_dwell;
    logic       bad_len;

    // Capture the lamp drives every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lamp_q <= 5'b0;
        else     lamp_q <= {bus.road_red, bus.road_yellow, bus.road_green, bus.ped_red, bus.ped_green};
    end

    lamp_phase_decoder u_dec (
        .lamp_i  (lamp_q),
        .phase_o (lamp_phase)
    );

    assign same_region = (lamp_phase == cur_phase_q) || (is_ped(lamp_phase) && is_ped(cur_phase_q));

    // An ALL_RED reached by resync has no known origin, so either exit is accepted
    always_comb begin
        legal_trans = 1'b0;
        case (cur_phase_q)
            PH_GREEN:      legal_trans = (lamp_phase == PH_YELLOW);
            PH_YELLOW:     legal_trans = (lamp_phase == PH_ALL_RED);
            PH_ALL_RED:    legal_trans =
                ((lamp_phase == PH_WALK) && ((ped_origin_q == PH_YELLOW) || (ped_origin_q == PH_UNKNOWN))) ||
                ((lamp_phase == PH_RED_YELLOW) && (is_ped(ped_origin_q) || (ped_origin_q == PH_UNKNOWN)));
            PH_WALK,
            PH_DARK:       legal_trans = (lamp_phase == PH_ALL_RED);
            PH_RED_YELLOW: legal_trans = (lamp_phase == PH_GREEN);
            default:       legal_trans = 1'b0;
        endcase
    end

    assign short_dwell = ((cur_phase_q == PH_GREEN)   && (dwell_q < MIN_GREEN_C)) ||
                         ((cur_phase_q == PH_ALL_RED) && (dwell_q < ALL_RED_MIN_C));
    assign bad_len     = ((cur_phase_q == PH_YELLOW)     && (dwell_q != YELLOW_CYC_C)) ||
                         ((cur_phase_q == PH_RED_YELLOW) && (dwell_q != RY_CYC_C));

    // Phase tracker state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_phase_q  <= PH_UNKNOWN;
            ped_origin_q <= PH_UNKNOWN;
            dwell_q      <= 8'd0;
        end else begin
            cur_phase_q  <= cur_phase_d;
            ped_origin_q <= ped_origin_d;
            dwell_q      <= dwell_d;
        end
    end

    // Phase tracker next state and fault classification; a conflict drops back to UNKNOWN
    // so the monitor resyncs on the next legal pattern instead of re-flagging it every cycle
    always_comb begin
        cur_phase_d  = cur_phase_q;
        ped_origin_d = ped_origin_q;
        dwell_d      = dwell_q;
        event_code   = FLT_NONE;
        if (cur_phase_q == PH_UNKNOWN) begin
            if (lamp_phase != PH_ILLEGAL) begin
                cur_phase_d  = lamp_phase;
                ped_origin_d = PH_UNKNOWN;
                dwell_d      = 8'd1;
            end
        end else if (lamp_phase == PH_ILLEGAL) begin
            event_code   = FLT_CONFLICT;
            cur_phase_d  = PH_UNKNOWN;
            ped_origin_d = PH_UNKNOWN;
            dwell_d      = 8'd0;
        end else if (same_region) begin
            cur_phase_d = lamp_phase;
            if (dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
            if (dwell_q == STUCK_AT_C) event_code = FLT_STUCK;
        end else begin
            cur_phase_d = lamp_phase;
            dwell_d     = 8'd1;
            if (lamp_phase == PH_ALL_RED) ped_origin_d = cur_phase_q;
            if (!legal_trans)     event_code = FLT_BAD_TRANS;
            else if (short_dwell) event_code = FLT_SHORT_DWELL;
            else if (bad_len)     event_code = FLT_BAD_LEN;
        end
        if (bus.clr) begin
            cur_phase_d  = PH_UNKNOWN;
            ped_origin_d = PH_UNKNOWN;
            dwell_d      = 8'd0;
        end
    end

    // Fault latch and event counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
            count_q <= 8'd0;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    // Clear applies first so an event in the same cycle is still latched
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        count_d = count_q;
        if (bus.clr) begin
            fault_d = 1'b0;
            code_d  = FLT_NONE;
        end
        if (event_code != FLT_NONE) begin
            if (!fault_d) begin
                fault_d = 1'b1;
                code_d  = event_code;
            end
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
    end

    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.fault_count = count_q;

`ifdef MON_FAILSAFE_EN
    localparam logic [7:0] FLASH_HALF_C = 8'(FLASH_HALF);

    logic       flash_q;
    logic [7:0] flash_cnt_q;

    // Yellow flash: on at fault rise, toggles every FLASH_HALF cycles, off with the fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_q     <= 1'b0;
            flash_cnt_q <= 8'd0;
        end else if (!fault_d) begin
            flash_q     <= 1'b0;
            flash_cnt_q <= 8'd0;
        end else if (!fault_q) begin
            flash_q     <= 1'b1;
            flash_cnt_q <= 8'd1;
        end else if (flash_cnt_q == FLASH_HALF_C) begin
            flash_q     <= ~flash_q;
            flash_cnt_q <= 8'd1;
        end else begin
            flash_cnt_q <= flash_cnt_q + 8'd1;
        end
    end

    assign bus.fs_active      = fault_q;
    assign bus.fs_road_yellow = flash_q;
`else
    assign bus.fs_active      = 1'b0;
    assign bus.fs_road_yellow = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam int MIN_GREEN = 6, YELLOW_CYC = 2, ALL_RED_MIN = 3, RY_CYC = 2;
    localparam int MAX_DWELL = 16, FLASH_HALF = 4;

    localparam logic [4:0] G = 5'b00110, Y = 5'b01010, AR = 5'b10010;
    localparam logic [4:0] W = 5'b10001, D = 5'b10000, RY = 5'b11010, BAD = 5'b00111;

    // bench phase ids
    localparam int P_G = 0, P_Y = 1, P_AR = 2, P_W = 3, P_D = 4, P_RY = 5, P_ILL = 6, P_UNK = 7;

    logic clk = 1'b0;
    logic rst;
    bit   chk_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    traffic_light_monitor_if bus ();

    traffic_light_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ph, m_run, m_org, m_code, m_count, m_t;
    bit         m_fault;
    logic [4:0] m_lamp;

    function automatic int classify(input logic [4:0] p);
        if (p == G)  return P_G;
        if (p == Y)  return P_Y;
        if (p == AR) return P_AR;
        if (p == W)  return P_W;
        if (p == D)  return P_D;
        if (p == RY) return P_RY;
        return P_ILL;
    endfunction

    function automatic bit ped(input int ph);
        return (ph == P_W) || (ph == P_D);
    endfunction

    // successor allowed after each phase (ALL_RED handled separately by origin)
    function automatic int next_of(input int ph);
        case (ph)
            P_G:  return P_Y;
            P_Y:  return P_AR;
            P_W:  return P_AR;
            P_D:  return P_AR;
            P_RY: return P_G;
            default: return -1;
        endcase
    endfunction

    task automatic m_reset();
        m_ph = P_UNK; m_run = 0; m_org = P_UNK;
        m_fault = 0; m_code = 0; m_count = 0; m_t = 0; m_lamp = 5'b0;
    endtask

    task automatic m_apply(input logic [4:0] p, input bit c);
        int ph;
        int code;
        bit ok;
        bit was;
        ph = classify(p);
        code = 0;
        was = m_fault;
        if (m_ph == P_UNK) begin
            if (ph != P_ILL) begin m_ph = ph; m_run = 1; m_org = P_UNK; end
        end else if (ph == P_ILL) begin
            code = 1; m_ph = P_UNK;
        end else if (ph == m_ph || (ped(ph) && ped(m_ph))) begin
            if (m_run < 255) m_run++;
            if (m_run == MAX_DWELL) code = 5;
            m_ph = ph;
        end else begin
            if (m_ph == P_AR)
                ok = (ph == P_W && (m_org == P_Y || m_org == P_UNK)) ||
                     (ph == P_RY && (ped(m_org) || m_org == P_UNK));
            else
                ok = (next_of(m_ph) == ph);
            if (!ok) code = 2;
            else if ((m_ph == P_G && m_run < MIN_GREEN) || (m_ph == P_AR && m_run < ALL_RED_MIN)) code = 3;
            else if ((m_ph == P_Y && m_run != YELLOW_CYC) || (m_ph == P_RY && m_run != RY_CYC)) code = 4;
            if (ph == P_AR) m_org = m_ph;
            m_ph = ph; m_run = 1;
        end
        if (c) begin m_fault = 0; m_code = 0; m_ph = P_UNK; end
        if (code != 0) begin
            if (!m_fault) begin m_fault = 1; m_code = code; end
            if (m_count < 255) m_count++;
        end
        if (m_fault && !was) m_t = 0;
        else if (m_fault)    m_t++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else begin
            m_apply(m_lamp, bus.clr);
            m_lamp = {bus.road_red, bus.road_yellow, bus.road_green, bus.ped_red, bus.ped_green};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on && rst === 1'b0) begin
            chk("fault",       32'(bus.fault),       32'(m_fault));
            chk("fault_code",  32'(bus.fault_code),  32'(m_code));
            chk("fault_count", 32'(bus.fault_count), 32'(m_count));
`ifdef MON_FAILSAFE_EN
            chk("fs_active",      32'(bus.fs_active),      32'(m_fault));
            chk("fs_road_yellow", 32'(bus.fs_road_yellow), 32'(m_fault && ((m_t / FLASH_HALF) % 2 == 0)));
`else
            chk("fs_active",      32'(bus.fs_active),      32'd0);
            chk("fs_road_yellow", 32'(bus.fs_road_yellow), 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [4:0] p, input int n, input bit c = 1'b0);
        repeat (n) begin
            @(negedge clk);
            {bus.road_red, bus.road_yellow, bus.road_green, bus.ped_red, bus.ped_green} = p;
            bus.clr = c;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {bus.road_red, bus.road_yellow, bus.road_green, bus.ped_red, bus.ped_green} = 5'b0;
        bus.clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cadence();
        drive(G, 6); drive(Y, 2); drive(AR, 3);
        drive(W, 5); drive(D, 2); drive(W, 2); drive(D, 2);
        drive(AR, 3); drive(RY, 2);
    endtask

    initial begin
        rst = 1'b1;
        bus.clr = 1'b0;
        {bus.road_red, bus.road_yellow, bus.road_green, bus.ped_red, bus.ped_green} = 5'b0;
        do_reset();
        chk_on = 1'b1;
        chk("reset fault",       32'(bus.fault),       32'd0);
        chk("reset fault_code",  32'(bus.fault_code),  32'd0);
        chk("reset fault_count", 32'(bus.fault_count), 32'd0);

        // three legal reference cycles
        repeat (3) cadence();
        drive(G, 2);
        chk("cadence fault", 32'(bus.fault),       32'd0);
        chk("cadence count", 32'(bus.fault_count), 32'd0);

        // lamp conflict during GREEN, then clear and resume
        drive(G, 3); drive(BAD, 1); drive(G, 3);
        chk("conflict fault", 32'(bus.fault),       32'd1);
        chk("conflict code",  32'(bus.fault_code),  32'd1);
        chk("conflict count", 32'(bus.fault_count), 32'd1);
        drive(G, 8);
        drive(G, 1, 1'b1);
        cadence();
        drive(G, 2);
        chk("clr fault", 32'(bus.fault),       32'd0);
        chk("clr code",  32'(bus.fault_code),  32'd0);
        chk("clr count", 32'(bus.fault_count), 32'd1);

        // GREEN straight to ALL_RED, later conflict keeps first code
        do_reset();
        drive(G, 6); drive(AR, 3); drive(BAD, 1); drive(AR, 2);
        chk("bad_trans code",  32'(bus.fault_code),  32'd2);
        chk("bad_trans count", 32'(bus.fault_count), 32'd2);

        // YELLOW held three cycles
        do_reset();
        drive(G, 6); drive(Y, 3); drive(AR, 3);
        chk("bad_len code", 32'(bus.fault_code), 32'd4);

        // GREEN only four cycles
        do_reset();
        drive(RY, 2); drive(G, 4); drive(Y, 2); drive(AR, 3);
        chk("short code", 32'(bus.fault_code), 32'd3);

        // ALL_RED held well past the watchdog: flagged once
        do_reset();
        drive(Y, 2); drive(AR, 20); drive(W, 3);
        chk("stuck code",  32'(bus.fault_code),  32'd5);
        chk("stuck count", 32'(bus.fault_count), 32'd1);

        // asynchronous reset mid-phase with a fault present
        do_reset();
        drive(G, 2); drive(BAD, 1); drive(G, 2);
        chk("pre-rst fault", 32'(bus.fault), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst fault",       32'(bus.fault),          32'd0);
        chk("async rst code",        32'(bus.fault_code),     32'd0);
        chk("async rst count",       32'(bus.fault_count),    32'd0);
        chk("async rst fs_active",   32'(bus.fs_active),      32'd0);
        chk("async rst fs_yellow",   32'(bus.fs_road_yellow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // fault_count saturation
        do_reset();
        repeat (260) begin drive(G, 1); drive(BAD, 1); end
        drive(G, 2);
        chk("sat count", 32'(bus.fault_count), 32'd255);
        chk("sat code",  32'(bus.fault_code),  32'd1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent safety monitor on the consuming side of the traffic controller's lamp bus. It samples the five lamp drives (ROAD_RED/YELLOW/GREEN, PED_RED/GREEN), decodes them into phases, and checks each phase sequence and dwell time against the crossing protocol. The first violation latches a sticky fault code. It sits beside the controller in the top level and feeds the lamp driver's failsafe override.

## Interface
- MIN_GREEN, 6: minimum cycles in CAR_GREEN.
- YELLOW_CYC, 2: exact cycles required in CAR_YELLOW.
- ALL_RED_MIN, 3: minimum cycles in ALL_RED.
- RY_CYC, 2: exact cycles required in CAR_RED_YELLOW.
- MAX_DWELL, 16: watchdog limit, in cycles, for any single phase. The pedestrian region (WALK/DARK combined) counts as one phase.
- FLASH_HALF, 4: half-period, in cycles, of the failsafe yellow flash.
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- road_red, road_yellow, road_green, ped_red, ped_green, in, 1 each: lamp drives, in the same clock domain.
- clr, in, 1: synchronous single-cycle fault clear.
- fault, out, 1: sticky fault flag.
- fault_code, out, 3: first-fault code.
- fault_count, out, 8: saturating count of all fault events.
- fs_active, out, 1: failsafe override active.
- fs_road_yellow, out, 1: flashing yellow during failsafe.

## Operation
- Input stage: the five lamp inputs are registered into lamp_q on every edge.
- Phase decode of lamp_q {RR,RY,RG,PR,PG}:
  - 00110 → GREEN
  - 01010 → YELLOW
  - 10010 → ALL_RED
  - 10001 → WALK
  - 10000 → DARK
  - 11010 → RED_YELLOW
  - any other pattern → ILLEGAL
- Tracked state: cur_phase, ped_origin (phase that preceded the current ALL_RED), and dwell (8-bit saturating counter).
- Legal transitions:
  - GREEN→YELLOW
  - YELLOW→ALL_RED
  - ALL_RED→WALK, only if ALL_RED was entered from YELLOW
  - ALL_RED→RED_YELLOW, only if ALL_RED was entered from WALK/DARK
  - WALK↔DARK
  - WALK/DARK→ALL_RED
  - RED_YELLOW→GREEN
- Dwell counter:
  - Resets to 1 on each phase change.
  - WALK↔DARK does not reset it.
- Fault conditions, in priority order (highest first):
  - 1 CONFLICT: ILLEGAL pattern.
  - 2 BAD_TRANS: phase change not in the legal list.
  - 3 SHORT_DWELL: leaving GREEN with dwell<MIN_GREEN, or leaving ALL_RED with dwell<ALL_RED_MIN.
  - 4 BAD_LEN: leaving YELLOW with dwell≠YELLOW_CYC, or leaving RED_YELLOW with dwell≠RY_CYC.
  - 5 STUCK: dwell reaches MAX_DWELL. Flagged once per phase occurrence.
- Fault latch:
  - The first event sets fault=1 and fault_code; later events do not overwrite the code.
  - fault_count increments on every event and saturates at 255.
- After reset or clr, cur_phase=UNKNOWN. The first decoded legal phase is accepted without transition or dwell checks.
- clr behaviour:
  - Clears fault and fault_code, and resyncs to UNKNOWN.
  - fault_count is not cleared.
  - clr together with a new event in the same cycle: the event is latched.

## Timing
- Reset values:
  - fault=0, fault_code=0, fault_count=0
  - fs_active=0, fs_road_yellow=0
  - lamp_q=0, cur_phase=UNKNOWN, dwell=0
- Latency: a pattern present at the inputs before edge k is captured at k and checked combinationally. Its fault is registered at k+1.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.
- Saturation: dwell stops at 255; fault_count stops at 255.
- Reference controller cadence, legal under the defaults:
  - GREEN 6 cycles
  - YELLOW 2
  - ALL_RED 3
  - WALK 5, then WALK/DARK alternating
  - ALL_RED 3
  - RED_YELLOW 2

## Configuration
- MON_FAILSAFE_EN defined:
  - fs_active follows fault.
  - fs_road_yellow toggles every FLASH_HALF cycles while fs_active=1, starting at 1 on the cycle fs_active rises.
  - fs_road_yellow is 0 when fs_active=0.
- MON_FAILSAFE_EN undefined: fs_active and fs_road_yellow are tied to 0 and the flash counter is not built.

## Structure
- Shared package traffic_pkg holds:
  - phase_t enum (GREEN, YELLOW, ALL_RED, WALK, DARK, RED_YELLOW, ILLEGAL, UNKNOWN)
  - fault_t enum (codes 0–5)
  - the six lamp-pattern constants
- Sub-module lamp_phase_decoder: combinational map from the 5-bit lamp vector to phase_t.

## Test plan
- Reference cadence with default parameters, 3 full cycles → fault=0 and fault_count=0 throughout.
- Drive 00111 (road green and ped green together) for one cycle during GREEN → fault=1 and fault_code=1 two edges later. With MON_FAILSAFE_EN, fs_road_yellow toggles every 4 cycles.
- GREEN→ALL_RED directly → fault_code=2. A later ILLEGAL pattern leaves fault_code=2 and raises fault_count to 2.
- YELLOW held 3 cycles → fault_code=4. Separately, GREEN held 4 cycles before YELLOW → fault_code=3.
- ALL_RED held 16 cycles → fault_code=5, raised exactly once.
- After a fault, pulse clr, then run the legal cadence → fault=0 and fault_count unchanged. Separately, assert rst mid-phase → all outputs 0 immediately.
